// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator datapath blocks:
// controller states, default widths and the requantisation clamp.
package cnn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OUT_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_POST  = 3'd3,
    ST_OUT   = 3'd4
  } pe_state_t;

  // Clamp v to the signed out_w-bit range, then optionally zero negatives.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int out_w,
                                                  input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    if (relu && (r < 64'sd0)) begin
      r = 64'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_lane.sv
// One MAC lane: registered product, wide accumulator with synchronous clear,
// and a registered shift/saturate/ReLU requantisation stage.
module pe_lane
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = 22,
  parameter int SH_W   = 5,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] w_data,
  input  logic              post_en,
  input  logic [SH_W-1:0]   shift,
  input  logic              relu_en,
  output logic [OUT_W-1:0]  res
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    a_x;
  logic signed [PW-1:0]    w_x;
  logic signed [PW-1:0]    prod_p1_d, prod_p1_q;
  logic                    vld_p1_d, vld_p1_q;
  logic signed [ACC_W-1:0] acc_p2_d, acc_p2_q;
  logic signed [ACC_W-1:0] sh_p2;
  logic signed [OUT_W-1:0] res_p3_d, res_p3_q;

  always_comb begin
    a_x       = {{DATA_W{a_data[DATA_W-1]}}, a_data};
    w_x       = {{DATA_W{w_data[DATA_W-1]}}, w_data};
    prod_p1_d = a_x * w_x;
    vld_p1_d  = vld_p0;

    // p1 -> p2: accumulate the registered product
    acc_p2_d = acc_p2_q;
    if (clr) begin
      acc_p2_d = '0;
    end else if (vld_p1_q) begin
      acc_p2_d = acc_p2_q + {{(ACC_W-PW){prod_p1_q[PW-1]}}, prod_p1_q};
    end

    // p2 -> p3: floor shift, saturate, optional ReLU
    sh_p2    = acc_p2_q >>> shift;
    res_p3_d = res_p3_q;
    if (post_en) begin
      res_p3_d = OUT_W'(sat_relu(64'(sh_p2), OUT_W, relu_en));
    end
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      acc_p2_q <= '0;
      res_p3_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      acc_p2_q <= acc_p2_d;
      res_p3_q <= res_p3_d;
    end
  end

  assign res = res_p3_q;

endmodule

// File: rtl/pe_array.sv
// Multi-lane MAC engine: sequences BRAM reads for one dot-product job,
// drives LANES pe_lane instances and presents the result on valid/ready.
module pe_array
  import cnn_pkg::*;
#(
  parameter  int LANES   = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int MAX_LEN = 64,
  parameter  int ADDR_W  = 10,
  parameter  int OUT_W   = OUT_W_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int ACC_W   = 2 * DATA_W + $clog2(MAX_LEN),
  localparam int SH_W    = $clog2(ACC_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [ADDR_W-1:0]       a_base,
  input  logic [ADDR_W-1:0]       b_base,
  input  logic [SH_W-1:0]         shift,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       a_addr,
  output logic [ADDR_W-1:0]       b_addr,
  input  logic [DATA_W-1:0]       a_rdata,
  input  logic [LANES*DATA_W-1:0] b_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_data
);

  pe_state_t         state_d, state_q;
  logic [LEN_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W-1:0] a_addr_d, a_addr_q;
  logic [ADDR_W-1:0] b_addr_d, b_addr_q;
  logic              rd_en_d, rd_en_q;
  logic              busy_d, busy_q;
  logic              out_valid_d, out_valid_q;
  logic [SH_W-1:0]   shift_d, shift_q;
  logic              relu_d, relu_q;
  logic              vld_p0_q;
  logic              clr;
  logic              post_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    clr         = 1'b0;
    post_en     = (state_q == ST_POST);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          shift_d  = shift;
          relu_d   = relu_en;
          a_addr_d = a_base;
          b_addr_d = b_base;
          clr      = 1'b1;
          if (len == '0) begin
            state_d = ST_POST;
          end else begin
            state_d = ST_FETCH;
            rd_en_d = 1'b1;
            cnt_d   = len - LEN_W'(1);
          end
        end
      end
      ST_FETCH: begin
        // cnt_q counts reads still to issue after the current one
        if (cnt_q == '0) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
          cnt_d   = LEN_W'(1);
        end else begin
          cnt_d    = cnt_q - LEN_W'(1);
          a_addr_d = a_addr_q + ADDR_W'(1);
          b_addr_d = b_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_POST;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_POST: begin
        state_d     = ST_OUT;
        out_valid_d = 1'b1;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      vld_p0_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      vld_p0_q    <= rd_en_q;
    end
  end

  // p0: BRAM data is valid the cycle after a read was issued
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SH_W   (SH_W),
      .OUT_W  (OUT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .vld_p0  (vld_p0_q),
      .a_data  (a_rdata),
      .w_data  (b_rdata[i*DATA_W +: DATA_W]),
      .post_en (post_en),
      .shift   (shift_q),
      .relu_en (relu_q),
      .res     (out_data[i*OUT_W +: OUT_W])
    );
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/pe_array.md
# pe_array

Parameterised multi-lane MAC engine for the CNN accelerator, replacing the single-PE datapath. It streams one activation vector from BRAM A and a packed per-lane weight word from BRAM B, and accumulates `LANES` dot products in parallel over a runtime length. It then requantises each result with an arithmetic shift, saturation and optional ReLU, and presents all lanes on a valid/ready output. It sits between the two BRAMs and the output writer inside `top`.

## Interface
- `LANES`, 4: parallel MAC lanes (≥1).
- `DATA_W`, 8: signed activation/weight width.
- `MAX_LEN`, 64: maximum dot-product length.
- `ADDR_W`, 10: BRAM address width.
- `OUT_W`, 8: signed output width per lane.
- Derived: `LEN_W`=clog2(MAX_LEN+1); `ACC_W`=2·DATA_W+clog2(MAX_LEN); `SH_W`=clog2(ACC_W).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `len` in LEN_W: number of elements in the dot product.
- `a_base` in ADDR_W: start address in BRAM A.
- `b_base` in ADDR_W: start address in BRAM B.
- `shift` in SH_W: arithmetic right-shift amount before saturation.
- `relu_en` in 1: clamp negative results to 0.
- `busy` out 1: high from start accept until the output handshake completes.
- `rd_en` out 1: BRAM read enable (shared by A and B).
- `a_addr` out ADDR_W: BRAM A address.
- `b_addr` out ADDR_W: BRAM B address.
- `a_rdata` in DATA_W: BRAM A data, 1-cycle read latency.
- `b_rdata` in LANES·DATA_W: BRAM B data, lane i in bits [i·DATA_W +: DATA_W].
- `out_valid` out 1: result vector valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out LANES·OUT_W: lane i result in bits [i·OUT_W +: OUT_W].

## Operation
- FSM states: IDLE, FETCH, DRAIN, POST, OUT.
- IDLE, start=1:
  - Latch len, bases, shift and relu_en; clear all accumulators.
  - If len=0, go to POST; otherwise go to FETCH.
- FETCH:
  - rd_en=1 for exactly len consecutive cycles.
  - a_addr and b_addr begin at their bases and increment by 1 each cycle.
  - Addresses wrap modulo 2^ADDR_W.
  - After the last read, go to DRAIN.
- DRAIN: hold 2 cycles while the product and accumulate stages empty, then go to POST.
- Lane datapath:
  - Register the signed product a_rdata × w_i, where w_i is lane i's DATA_W slice of b_rdata.
  - On the next cycle, add the product into the ACC_W signed accumulator.
  - ACC_W is sized so the accumulator cannot overflow.
- POST, one cycle, registered per lane:
  - Compute r = acc >>> shift (floor).
  - Saturate r to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - If relu_en, clamp negative values to 0.
  - Go to OUT.
- OUT:
  - out_valid=1; out_data is held stable until out_ready=1.
  - On the handshake edge, go to IDLE; busy and out_valid fall at that edge.
- start outside IDLE is ignored; there is no queuing.
- rst at any point:
  - Next edge forces IDLE.
  - busy, rd_en, out_valid = 0; out_data, addresses and accumulators = 0.
  - In-flight job is discarded.

## Timing
- All outputs are registered. Reset values are all zero.
- Start accept edge = E0.
  - rd_en is high during cycles E0..E(len−1); element k is addressed in cycle Ek.
  - Data for element k returns after E(k+1); its product is registered at E(k+2) and accumulated at E(k+3).
  - out_valid rises at E(len+3), which is 3 cycles after rd_en falls.
- len=0: out_valid rises at E1 with out_data=0 in every lane.
- Back-to-back: with out_ready=1, the next start is accepted at the earliest one cycle after the handshake edge (IDLE must be visible).
- Config inputs may change freely after E0.

## Structure
- Shared package `cnn_pkg`:
  - FSM state enum.
  - Default DATA_W/OUT_W constants.
  - Saturate/ReLU function, reused by later pooling blocks.
- One sub-module `pe_lane`, instantiated LANES times: product register, accumulator, POST requant stage, and a synchronous clear.
- The FSM and address counters live in `pe_array`.

## Test plan
All cases use LANES=4, DATA_W=8, OUT_W=8, MAX_LEN=64.
- **Basic:** len=3, A=[1,2,3], weight lanes [1,1,1]/[−1,−1,−1]/[2,0,0]/[127,127,127], shift=0, relu off → out_data lanes 6/−6/2/127 (762 saturated); out_valid at E6; rd_en high exactly 3 cycles; addresses base..base+2.
- **ReLU:** repeat Basic with relu_en=1 → 6/0/2/127.
- **Shift floor:** len=4, A=[10,10,10,10], weights 3/−3/0/−1 plus a fifth element making lane3 −121 (len=5, A5=1, w=[0,0,0,−81]), shift=2 → lane3 = −31 (floor); lane0 len=4 variant gives 120>>>2 = 30 and −120>>>2 = −30.
- **Backpressure:** out_ready low 5 cycles after out_valid → out_data stable, busy high, start pulses ignored; out_ready=1 → busy falls same edge, next start accepted one cycle later and produces a correct independent result.
- **Edge lengths:** len=0 → zeros at E1. len=64 with a_base=1020 (ADDR_W=10) → addresses wrap 1023→0; all-127 × all-127 gives acc 1,032,256, and shift=13 yields 126.
- **Reset mid-FETCH:** rst at E2 → busy/rd_en/out_valid 0 next edge; the following Basic job returns exact Basic values (no stale accumulation).
